// File: rtl/instr_sequencer.sv
// Instruction-issue sequencer: fetches words from synchronous program memory, holds each
// for the control unit until it reports completion, and owns the PC on the shared bus.
module instr_sequencer #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic [DATA_W-1:0] o_instr,
    output logic              o_new_instr,
    input  logic              i_cu_done,
    input  logic              i_pcin,
    input  logic              i_pcout,
    input  logic [DATA_W-1:0] i_bus_in,
    output logic [DATA_W-1:0] o_bus_out,
    output logic              o_busy
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StExec,
        StRecover
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;

    // Only the low ADDR_W bits of the bus can address program memory.
    logic w_bus_in_unused;
    assign w_bus_in_unused = ^i_bus_in[DATA_W-1:ADDR_W];

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (i_run) w_state_next = StFetch;
            StFetch:   w_state_next = StWait;
            StWait:    w_state_next = StExec;
            StExec:    if (i_cu_done) w_state_next = StRecover;
            StRecover: w_state_next = i_run ? StFetch : StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_mem_rd    = (r_state == StFetch);
        o_new_instr = (r_state != StExec);
        o_busy      = (r_state != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_pc    <= ADDR_W'(RESET_PC);
            r_instr <= '0;
        end else begin
            unique case (r_state)
                StWait: begin
                    r_instr <= i_mem_data;
                    r_pc    <= r_pc + ADDR_W'(1);
                end
                StExec: begin
                    if (i_pcin) r_pc <= i_bus_in[ADDR_W-1:0];
                end
                StRecover: r_instr <= '0;
                default: ;
            endcase
        end
    end

    assign o_mem_addr = r_pc;
    assign o_instr    = r_instr;
    assign o_bus_out  = i_pcout ? DATA_W'(r_pc) : '0;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a cycle-by-cycle vector table against a small
// synchronous memory model, plus hand-written reset-abort sequences.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic        new_instr;
    logic        cu_done;
    logic        pcin;
    logic        pcout;
    logic [15:0] bus_in;
    logic [15:0] bus_out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [256];

    typedef struct {
        logic        run;
        logic        cu;
        logic        pcin;
        logic        pcout;
        logic [15:0] bin;
        logic        rd;
        logic [7:0]  addr;
        logic        ni;
        logic [15:0] ins;
        logic        busy;
        logic [15:0] bout;
    } vec_t;

    vec_t vecs[$];

    instr_sequencer #(
        .DATA_W  (16),
        .ADDR_W  (8),
        .RESET_PC(0)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_run      (run),
        .o_mem_addr (mem_addr),
        .o_mem_rd   (mem_rd),
        .i_mem_data (mem_data),
        .o_instr    (instr),
        .o_new_instr(new_instr),
        .i_cu_done  (cu_done),
        .i_pcin     (pcin),
        .i_pcout    (pcout),
        .i_bus_in   (bus_in),
        .o_bus_out  (bus_out),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic c, input logic pi, input logic po,
                         input logic [15:0] b);
        run     = r;
        cu_done = c;
        pcin    = pi;
        pcout   = po;
        bus_in  = b;
    endtask

    function automatic void add(input logic r, input logic c, input logic pi, input logic po,
                                input logic [15:0] b, input logic rd, input logic [7:0] a,
                                input logic ni, input logic [15:0] ins, input logic bz,
                                input logic [15:0] bo);
        vec_t v;
        v.run = r; v.cu = c; v.pcin = pi; v.pcout = po; v.bin = b;
        v.rd = rd; v.addr = a; v.ni = ni; v.ins = ins; v.busy = bz; v.bout = bo;
        vecs.push_back(v);
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h02FF;
        mem[8'h01] = 16'h1610;
        mem[8'h02] = 16'h2260;
        mem[8'h03] = 16'h3333;
        mem[8'h04] = 16'h4444;
        mem[8'h05] = 16'h5555;
        mem[8'h40] = 16'h4040;
        mem[8'h41] = 16'h4141;
        mem[8'hFF] = 16'hF0F0;
        mem_data   = 16'h0000;

        //  run cu pi po bus_in    rd addr  ni instr    bz bus_out
        add(1, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 16'h0000, 0, 16'h0000); // IDLE
        add(1, 0, 0, 0, 16'h0000, 1, 8'h00, 1, 16'h0000, 1, 16'h0000); // FETCH @0
        add(1, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 16'h0000, 1, 16'h0000); // WAIT
        add(1, 0, 0, 1, 16'h0000, 0, 8'h01, 0, 16'h02FF, 1, 16'h0001); // EXEC
        add(1, 1, 0, 0, 16'h0000, 0, 8'h01, 0, 16'h02FF, 1, 16'h0000);
        add(1, 0, 0, 0, 16'h0000, 0, 8'h01, 1, 16'h02FF, 1, 16'h0000); // RECOVER
        add(1, 0, 1, 0, 16'h00AA, 1, 8'h01, 1, 16'h0000, 1, 16'h0000); // FETCH @1, pcin ignored
        add(1, 1, 0, 0, 16'h0000, 0, 8'h01, 1, 16'h0000, 1, 16'h0000); // WAIT, cu_done ignored
        add(1, 0, 0, 1, 16'h0000, 0, 8'h02, 0, 16'h1610, 1, 16'h0002);
        add(1, 1, 0, 0, 16'h0000, 0, 8'h02, 0, 16'h1610, 1, 16'h0000);
        add(1, 0, 0, 0, 16'h0000, 0, 8'h02, 1, 16'h1610, 1, 16'h0000);
        add(1, 0, 0, 0, 16'h0000, 1, 8'h02, 1, 16'h0000, 1, 16'h0000); // FETCH @2
        add(1, 0, 0, 0, 16'h0000, 0, 8'h02, 1, 16'h0000, 1, 16'h0000);
        add(1, 0, 0, 0, 16'h0000, 0, 8'h03, 0, 16'h2260, 1, 16'h0000);
        add(1, 1, 0, 0, 16'h0000, 0, 8'h03, 0, 16'h2260, 1, 16'h0000);
        add(1, 0, 0, 0, 16'h0000, 0, 8'h03, 1, 16'h2260, 1, 16'h0000);
        add(1, 0, 0, 0, 16'h0000, 1, 8'h03, 1, 16'h0000, 1, 16'h0000); // FETCH @3
        add(1, 0, 0, 0, 16'h0000, 0, 8'h03, 1, 16'h0000, 1, 16'h0000);
        add(1, 1, 1, 0, 16'hAB40, 0, 8'h04, 0, 16'h3333, 1, 16'h0000); // branch + done
        add(1, 0, 0, 0, 16'h0000, 0, 8'h40, 1, 16'h3333, 1, 16'h0000);
        add(1, 0, 0, 0, 16'h0000, 1, 8'h40, 1, 16'h0000, 1, 16'h0000); // FETCH @40
        add(1, 0, 0, 0, 16'h0000, 0, 8'h40, 1, 16'h0000, 1, 16'h0000);
        add(1, 1, 1, 0, 16'h0005, 0, 8'h41, 0, 16'h4040, 1, 16'h0000); // jump to 5
        add(1, 0, 0, 0, 16'h0000, 0, 8'h05, 1, 16'h4040, 1, 16'h0000);
        add(1, 0, 0, 0, 16'h0000, 1, 8'h05, 1, 16'h0000, 1, 16'h0000); // FETCH @5
        add(1, 0, 0, 0, 16'h0000, 0, 8'h05, 1, 16'h0000, 1, 16'h0000);
        add(1, 0, 0, 1, 16'h0000, 0, 8'h06, 0, 16'h5555, 1, 16'h0006); // pcout = 6
        add(1, 1, 1, 0, 16'h12FF, 0, 8'h06, 0, 16'h5555, 1, 16'h0000); // jump to FF
        add(1, 0, 0, 0, 16'h0000, 0, 8'hFF, 1, 16'h5555, 1, 16'h0000);
        add(1, 0, 0, 0, 16'h0000, 1, 8'hFF, 1, 16'h0000, 1, 16'h0000); // FETCH @FF
        add(1, 0, 0, 0, 16'h0000, 0, 8'hFF, 1, 16'h0000, 1, 16'h0000);
        add(1, 1, 0, 1, 16'h0000, 0, 8'h00, 0, 16'hF0F0, 1, 16'h0000); // wrapped pc
        add(1, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 16'hF0F0, 1, 16'h0000);
        add(1, 0, 0, 0, 16'h0000, 1, 8'h00, 1, 16'h0000, 1, 16'h0000); // FETCH @0
        add(1, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 16'h0000, 1, 16'h0000);
        add(0, 0, 0, 0, 16'h0000, 0, 8'h01, 0, 16'h02FF, 1, 16'h0000); // run drops mid-EXEC
        add(0, 1, 0, 0, 16'h0000, 0, 8'h01, 0, 16'h02FF, 1, 16'h0000);
        add(0, 0, 0, 0, 16'h0000, 0, 8'h01, 1, 16'h02FF, 1, 16'h0000); // RECOVER
        add(0, 1, 1, 1, 16'h0077, 0, 8'h01, 1, 16'h0000, 0, 16'h0001); // IDLE, ignores pcin
        add(0, 0, 0, 0, 16'h0000, 0, 8'h01, 1, 16'h0000, 0, 16'h0000);

        drive(1, 1, 1, 0, 16'h00CC);
        rst = 1'b0;
        repeat (2) step();
        chk("rst rd",    {15'd0, mem_rd},    16'd0);
        chk("rst addr",  {8'd0, mem_addr},   16'h0000);
        chk("rst ni",    {15'd0, new_instr}, 16'd1);
        chk("rst instr", instr,              16'h0000);
        chk("rst busy",  {15'd0, busy},      16'd0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].run, vecs[i].cu, vecs[i].pcin, vecs[i].pcout, vecs[i].bin);
            #1;
            chk($sformatf("v%0d rd", i),    {15'd0, mem_rd},    {15'd0, vecs[i].rd});
            chk($sformatf("v%0d addr", i),  {8'd0, mem_addr},   {8'd0, vecs[i].addr});
            chk($sformatf("v%0d ni", i),    {15'd0, new_instr}, {15'd0, vecs[i].ni});
            chk($sformatf("v%0d instr", i), instr,              vecs[i].ins);
            chk($sformatf("v%0d busy", i),  {15'd0, busy},      {15'd0, vecs[i].busy});
            chk($sformatf("v%0d bus", i),   bus_out,            vecs[i].bout);
            step();
        end

        // Reset abort mid-EXEC: pcin and cu_done asserted alongside must be overridden.
        drive(1, 0, 0, 0, 16'h0000);
        step();                                   // FETCH @1
        chk("ab fetch rd", {15'd0, mem_rd}, 16'd1);
        step();                                   // WAIT
        step();                                   // EXEC
        chk("ab exec instr", instr, 16'h1610);
        chk("ab exec ni", {15'd0, new_instr}, 16'd0);
        rst = 1'b0;
        drive(1, 1, 1, 0, 16'h0033);
        step();
        chk("ab busy",  {15'd0, busy},      16'd0);
        chk("ab addr",  {8'd0, mem_addr},   16'h0000);
        chk("ab instr", instr,              16'h0000);
        chk("ab ni",    {15'd0, new_instr}, 16'd1);
        step();
        rst = 1'b1;
        drive(0, 0, 0, 0, 16'h0000);
        step();
        chk("ab idle rd",   {15'd0, mem_rd}, 16'd0);
        chk("ab idle busy", {15'd0, busy},   16'd0);

        // Reset mid-FETCH.
        drive(1, 0, 0, 0, 16'h0000);
        step();
        chk("rf fetch rd", {15'd0, mem_rd}, 16'd1);
        rst = 1'b0;
        step();
        chk("rf rd",   {15'd0, mem_rd}, 16'd0);
        chk("rf busy", {15'd0, busy},   16'd0);
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
